// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//   Byte FIFO plus drain sequencer sitting between display_formatter and
//   uart_tx. It absorbs bursts of formatted bytes and hands them to the UART
//   one at a time using the tx_start / tx_busy handshake.
//
// Parameters
//   DEPTH_LOG2 : log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2)
//   BUSY_WAIT  : cycles to wait after tx_start for tx_busy to rise before the
//                byte is deemed sent
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   wr_data/valid : byte write from the formatter, one byte per cycle
//   buf_full      : level == DEPTH (formatter backpressure)
//   buf_empty     : level == 0
//   level         : current occupancy (stored bytes)
//   overflow      : sticky, a write was dropped; clr_overflow clears it
//   tx_busy       : from uart_tx
//   tx_start      : one-cycle launch pulse to uart_tx
//   tx_data       : byte to uart_tx, stable from tx_start until back in IDLE
//
// Build option
//   UART_TX_BUF_CRLF_EN : when defined, each 0x0A leaving the FIFO is preceded
//                         by an inserted 0x0D (not counted in level).
module uart_tx_buffer #(
  parameter int DEPTH_LOG2 = 5,
  parameter int BUSY_WAIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  buf_full,
  output logic                  buf_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  input  logic                  clr_overflow,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW    = (BUSY_WAIT < 2) ? 1 : $clog2(BUSY_WAIT + 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [CW-1:0]       BW_LOAD   = CW'(BUSY_WAIT);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                     state, state_nxt;
  logic [DEPTH-1:0][7:0]      mem;
  logic [DEPTH_LOG2-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]              cnt;
  logic [7:0]                 head;
  logic                       pop, load_data, cnt_load, cnt_dec, wr_en;
`ifdef UART_TX_BUF_CRLF_EN
  logic                       cr_sent, ins_cr;
`endif

  assign head      = mem[rd_ptr];
  assign buf_full  = (level == DEPTH_LVL);
  assign buf_empty = (level == '0);
  // A pop in the same cycle frees a slot, so a full buffer can still accept.
  assign wr_en     = wr_valid && (!buf_full || pop);

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_data = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    tx_start  = 1'b0;
`ifdef UART_TX_BUF_CRLF_EN
    ins_cr    = 1'b0;
`endif
    case (state)
      IDLE:
        // Never launch while the UART still reports busy.
        if (!buf_empty && !tx_busy) begin
          state_nxt = LAUNCH;
          load_data = 1'b1;
`ifdef UART_TX_BUF_CRLF_EN
          // First visit to a 0x0A sends 0x0D and leaves the byte in place.
          if (head == 8'h0A && !cr_sent) ins_cr = 1'b1;
          else                           pop    = 1'b1;
`else
          pop = 1'b1;
`endif
        end
      LAUNCH: begin
        tx_start  = 1'b1;
        cnt_load  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY:
        // Wait window is BUSY_WAIT cycles long; counter runs BUSY_WAIT..1.
        if (tx_busy)       state_nxt = WAIT_DONE;
        else if (cnt <= 1) state_nxt = IDLE;
        else               cnt_dec   = 1'b1;
      WAIT_DONE:
        if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (clr_overflow)           overflow <= 1'b0;
      else if (wr_valid && !wr_en) overflow <= 1'b1;
    end

  // ---------------- launch datapath ----------------
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_data <= 8'h00;
      cnt     <= '0;
    end else begin
      if (load_data) begin
`ifdef UART_TX_BUF_CRLF_EN
        tx_data <= ins_cr ? 8'h0D : head;
`else
        tx_data <= head;
`endif
      end
      if (cnt_load)     cnt <= BW_LOAD;
      else if (cnt_dec) cnt <= cnt - 1'b1;
    end

`ifdef UART_TX_BUF_CRLF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      cr_sent <= 1'b0;
    else if (ins_cr) cr_sent <= 1'b1;
    else if (pop)    cr_sent <= 1'b0;
`endif

endmodule
